// File: rtl/serial_parity_rx.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, XOR parity bit, stop bit.
// Reports the received word with parity/framing status and keeps a saturating error count.
module serial_parity_rx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned ODD_PARITY = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  output logic              parity_err,
  output logic              frame_err,
  output logic              busy,
  output logic [CNT_W-1:0]  err_count
);

  localparam int unsigned IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
  localparam logic PAR_EXP = 1'(ODD_PARITY);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  logic [1:0]        state_q,      state_d;
  logic [IDX_W-1:0]  idx_q,        idx_d;
  logic [DATA_W-1:0] shift_q,      shift_d;
  logic              acc_q,        acc_d;
  logic [DATA_W-1:0] data_out_q,   data_out_d;
  logic              out_valid_q,  out_valid_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q,  frame_err_d;
  logic [CNT_W-1:0]  err_count_q,  err_count_d;

  // Next-state and output logic; everything holds unless a bit strobe arrives.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    shift_d      = shift_q;
    acc_d        = acc_q;
    data_out_d   = data_out_q;
    out_valid_d  = 1'b0;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    err_count_d  = err_count_q;

    if (in_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (!in_bit) begin
            state_d = ST_DATA;
            idx_d   = '0;
            acc_d   = 1'b0;
          end
        end
        ST_DATA: begin
          shift_d[idx_q] = in_bit;
          acc_d          = acc_q ^ in_bit;
          idx_d          = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = ST_PARITY;
          end
        end
        ST_PARITY: begin
          acc_d   = acc_q ^ in_bit;
          state_d = ST_STOP;
        end
        ST_STOP: begin
          // Stop bit is not break-checked; a low stop simply flags the frame.
          state_d      = ST_IDLE;
          data_out_d   = shift_q;
          parity_err_d = (acc_q != PAR_EXP);
          frame_err_d  = !in_bit;
          out_valid_d  = 1'b1;
          if ((parity_err_d || frame_err_d) && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      shift_q      <= '0;
      acc_q        <= 1'b0;
      data_out_q   <= '0;
      out_valid_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      shift_q      <= shift_d;
      acc_q        <= acc_d;
      data_out_q   <= data_out_d;
      out_valid_q  <= out_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign data_out   = data_out_q;
  assign out_valid  = out_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign err_count  = err_count_q;
  assign busy       = (state_q != ST_IDLE);

endmodule
